// File: rtl/sdf_twiddle_gen_if.sv
// Sample/twiddle bus between one SDF stage datapath and its control/twiddle generator.
// The inv member exists only when SDF_TWIDDLE_INV_EN is defined.
interface sdf_twiddle_gen_if #(
  parameter int unsigned W_WIDTH = 24
);
  logic               in_valid;
`ifdef SDF_TWIDDLE_INV_EN
  logic               inv;
`endif
  logic [1:0]         state;
  logic [W_WIDTH-1:0] w_r;
  logic [W_WIDTH-1:0] w_i;
  logic               out_valid;
  logic               flushing;

  modport master (
`ifdef SDF_TWIDDLE_INV_EN
    output inv,
`endif
    output in_valid,
    input  state, w_r, w_i, out_valid, flushing
  );

  modport slave (
`ifdef SDF_TWIDDLE_INV_EN
    input  inv,
`endif
    input  in_valid,
    output state, w_r, w_i, out_valid, flushing
  );
endinterface

// File: rtl/sdf_twiddle_gen.sv
// Control and twiddle generator for one radix-2 SDF FFT stage (4..64 points).
// Define SDF_TWIDDLE_INV_EN to add the inv input that conjugates the twiddle.
module sdf_twiddle_gen #(
  parameter int unsigned LOG2N   = 6,
  parameter int unsigned STAGE   = 0,
  parameter int unsigned W_WIDTH = 24,
  parameter int unsigned FRAC    = 8
) (
  input  logic              clk,
  input  logic              rst,
  sdf_twiddle_gen_if.slave  bus
);

  localparam int unsigned PW    = LOG2N - STAGE;
  localparam int unsigned D     = 2 ** (PW - 1);
  localparam int unsigned SH    = STAGE + 6 - LOG2N;
  localparam int unsigned ONE   = 2 ** FRAC;
  localparam longint      PI_Q30 = 64'sd3373259426;

  typedef enum logic [1:0] {S_FILL = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} mode_e;

  // round(2^FRAC * cos(pi*j/32)) for j in 0..16, via a Q30 Taylor series
  function automatic int cos_frac(input int j);
    longint x, x2, term, acc;
    x    = (PI_Q30 * longint'(j)) >>> 5;
    x2   = (x * x) >>> 30;
    term = longint'(1) <<< 30;
    acc  = term;
    for (int n = 1; n <= 12; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n)));
      acc  = acc + term;
    end
    return int'((acc + (longint'(1) <<< (29 - FRAC))) >>> (30 - FRAC));
  endfunction

  logic [W_WIDTH-1:0] cos_tbl  [32];
  logic [W_WIDTH-1:0] nsin_tbl [32];

  // Quarter-wave symmetry: cos(m) from C(m) or -C(32-m), sin(m) = C(|m-16|)
  for (genvar g = 0; g < 32; g++) begin : g_tbl
    localparam int CR = (g <= 16) ? cos_frac(g) : -cos_frac(32 - g);
    localparam int NS = -cos_frac((g >= 16) ? (g - 16) : (16 - g));
    assign cos_tbl[g]  = W_WIDTH'(CR);
    assign nsin_tbl[g] = W_WIDTH'(NS);
  end

  mode_e         mode, mode_nxt;
  logic [PW-1:0] fill_cnt, fill_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [PW-1:0] flush_cnt, flush_nxt;
  logic          in_valid_d;

  logic               adv_c;
  logic [1:0]         state_c;
  logic [W_WIDTH-1:0] w_r_c;
  logic [W_WIDTH-1:0] w_i_c;
  logic [5:0]         k_c;
  logic [4:0]         m_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode       <= S_FILL;
      fill_cnt   <= '0;
      phase      <= '0;
      flush_cnt  <= '0;
      in_valid_d <= 1'b0;
    end else begin
      mode       <= mode_nxt;
      fill_cnt   <= fill_nxt;
      phase      <= phase_nxt;
      flush_cnt  <= flush_nxt;
      in_valid_d <= bus.in_valid;
    end
  end

  // Next mode and counters; a drop of in_valid only flushes at a frame boundary
  always_comb begin
    mode_nxt  = mode;
    fill_nxt  = fill_cnt;
    phase_nxt = phase;
    flush_nxt = flush_cnt;
    case (mode)
      S_FILL: begin
        if (bus.in_valid) begin
          fill_nxt = fill_cnt + PW'(1);
          if (fill_cnt == PW'(D - 1)) begin
            mode_nxt  = S_RUN;
            phase_nxt = '0;
          end
        end
      end
      S_RUN: begin
        if (bus.in_valid) begin
          phase_nxt = phase + PW'(1);
        end else if (in_valid_d && (phase == '0)) begin
          mode_nxt  = S_FLUSH;
          flush_nxt = '0;
        end
      end
      S_FLUSH: begin
        if (bus.in_valid) begin
          mode_nxt  = S_RUN;
          phase_nxt = phase + PW'(1);
          flush_nxt = '0;
        end else if (flush_cnt == PW'(D - 1)) begin
          mode_nxt  = S_FILL;
          fill_nxt  = '0;
          phase_nxt = '0;
          flush_nxt = '0;
        end else begin
          phase_nxt = phase + PW'(1);
          flush_nxt = flush_cnt + PW'(1);
        end
      end
      default: begin
        mode_nxt  = S_FILL;
        fill_nxt  = '0;
        phase_nxt = '0;
        flush_nxt = '0;
      end
    endcase
  end

  // Zero-latency decode of the current sample's state and twiddle
  always_comb begin
    adv_c   = bus.in_valid | (mode == S_FLUSH);
    state_c = 2'd0;
    w_r_c   = W_WIDTH'(ONE);
    w_i_c   = '0;
    k_c     = 6'(phase) - 6'(D);
    m_c     = 5'(k_c << SH);
    if (mode != S_FILL) begin
      state_c = (phase < PW'(D)) ? 2'd1 : 2'd2;
    end
    if (state_c == 2'd2) begin
      w_r_c = cos_tbl[m_c];
      w_i_c = nsin_tbl[m_c];
    end
`ifdef SDF_TWIDDLE_INV_EN
    if (bus.inv) begin
      w_i_c = -w_i_c;
    end
`endif
  end

  assign bus.state     = state_c;
  assign bus.w_r       = w_r_c;
  assign bus.w_i       = w_i_c;
  assign bus.out_valid = adv_c & (mode != S_FILL);
  assign bus.flushing  = (mode == S_FLUSH);

endmodule

// File: tb/tb_sdf_twiddle_gen.sv
// Directed bench for sdf_twiddle_gen: D=2, D=32 and D=1 stages at LOG2N=6, FRAC=8.
module tb_sdf_twiddle_gen;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  sdf_twiddle_gen_if #(.W_WIDTH(24)) bus_a ();
  sdf_twiddle_gen_if #(.W_WIDTH(24)) bus_b ();
  sdf_twiddle_gen_if #(.W_WIDTH(24)) bus_c ();

  sdf_twiddle_gen #(.LOG2N(6), .STAGE(4), .W_WIDTH(24), .FRAC(8)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  sdf_twiddle_gen #(.LOG2N(6), .STAGE(0), .W_WIDTH(24), .FRAC(8)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );
  sdf_twiddle_gen #(.LOG2N(6), .STAGE(5), .W_WIDTH(24), .FRAC(8)) u_c (
    .clk(clk), .rst(rst), .bus(bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Stage A (D=2) directed run: stall, frame-boundary flush, fill hold, aborted flush
  int t_iv [26] = '{1,1,1,0,1,1,1,1,1,0,0,0,0,0,1,1,1,1,1,1,0,0,1,1,1,1};
  int t_st [26] = '{1,1,2,2,2,1,1,2,2,1,1,1,0,0,0,0,1,1,2,2,1,1,1,2,2,1};
  int t_ov [26] = '{1,1,1,0,1,1,1,1,1,0,1,1,0,0,0,0,1,1,1,1,0,1,1,1,1,1};
  int t_fl [26] = '{0,0,0,0,0,0,0,0,0,0,1,1,0,0,0,0,0,0,0,0,0,1,1,0,0,0};
  int a_seq [10] = '{0,0,1,1,2,2,1,1,2,2};
  int c_seq [5]  = '{0,1,2,1,2};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_b.in_valid = 1'b1;
    bus_c.in_valid = 1'b1;
`ifdef SDF_TWIDDLE_INV_EN
    bus_a.inv = 1'b0;
    bus_b.inv = 1'b0;
    bus_c.inv = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_state",     32'(bus_a.state),     32'd0);
    check("rst_w_r",       32'(bus_a.w_r),       32'h000100);
    check("rst_w_i",       32'(bus_a.w_i),       32'h000000);
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_flushing",  32'(bus_a.flushing),  32'd0);
    check("rst_b_state",   32'(bus_b.state),     32'd0);
    check("rst_c_state",   32'(bus_c.state),     32'd0);

    rst = 1'b0;
    bus_b.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("a_seq_state", 32'(bus_a.state), 32'(a_seq[i]));
      if (i == 0) check("a_fill_out_valid", 32'(bus_a.out_valid), 32'd0);
      if (i == 2) check("a_run_out_valid",  32'(bus_a.out_valid), 32'd1);
      if (i == 4) begin
        check("a_bf0_w_r", 32'(bus_a.w_r), 32'h000100);
        check("a_bf0_w_i", 32'(bus_a.w_i), 32'h000000);
      end
      if (i == 5) begin
        check("a_bf1_w_r", 32'(bus_a.w_r), 32'h000000);
        check("a_bf1_w_i", 32'(bus_a.w_i), 32'hFFFF00);
      end
      if (i < 5) check("c_d1_state", 32'(bus_c.state), 32'(c_seq[i]));
      if (i == 2) check("c_d1_w_r", 32'(bus_c.w_r), 32'h000100);
      next_cycle();
    end

    for (int c = 0; c < 26; c++) begin
      bus_a.in_valid = (t_iv[c] != 0);
`ifdef SDF_TWIDDLE_INV_EN
      bus_a.inv = (c == 24);
`endif
      #1;
      check("a_tbl_state",     32'(bus_a.state),     32'(t_st[c]));
      check("a_tbl_out_valid", 32'(bus_a.out_valid), 32'(t_ov[c]));
      check("a_tbl_flushing",  32'(bus_a.flushing),  32'(t_fl[c]));
      if (c == 3) check("a_stall_w_i", 32'(bus_a.w_i), 32'hFFFF00);
      if (c == 4) check("a_resume_w_i", 32'(bus_a.w_i), 32'hFFFF00);
      if (c == 23) check("a_abort_w_r", 32'(bus_a.w_r), 32'h000100);
`ifdef SDF_TWIDDLE_INV_EN
      if (c == 24) check("a_inv_w_i", 32'(bus_a.w_i), 32'h000100);
`else
      if (c == 24) check("a_fwd_w_i", 32'(bus_a.w_i), 32'hFFFF00);
`endif
      next_cycle();
    end
`ifdef SDF_TWIDDLE_INV_EN
    bus_a.inv = 1'b0;
`endif

    #1;
    check("b_fill_hold_state", 32'(bus_b.state),     32'd0);
    check("b_fill_hold_ov",    32'(bus_b.out_valid), 32'd0);

    // Stage B (D=32): 32 fill samples, then one full 64-phase frame plus wrap
    bus_b.in_valid = 1'b1;
    for (int c = 0; c <= 96; c++) begin
      int p;
      int exp_st;
      p = (c - 32) % 64;
      exp_st = (c < 32) ? 0 : ((p < 32) ? 1 : 2);
      #1;
      check("b_state", 32'(bus_b.state), 32'(exp_st));
      if (c == 64) begin
        check("b_m0_w_r", 32'(bus_b.w_r), 32'h000100);
        check("b_m0_w_i", 32'(bus_b.w_i), 32'h000000);
      end
      if (c == 65) begin
        check("b_m1_w_r", 32'(bus_b.w_r), 32'h0000FF);
        check("b_m1_w_i", 32'(bus_b.w_i), 32'hFFFFE7);
      end
      if (c == 68) begin
        check("b_m4_w_r", 32'(bus_b.w_r), 32'h0000ED);
        check("b_m4_w_i", 32'(bus_b.w_i), 32'hFFFF9E);
      end
      if (c == 72) begin
        check("b_m8_w_r", 32'(bus_b.w_r), 32'h0000B5);
        check("b_m8_w_i", 32'(bus_b.w_i), 32'hFFFF4B);
      end
      if (c == 80) begin
        check("b_m16_w_r", 32'(bus_b.w_r), 32'h000000);
        check("b_m16_w_i", 32'(bus_b.w_i), 32'hFFFF00);
      end
      if (c == 88) begin
        check("b_m24_w_r", 32'(bus_b.w_r), 32'hFFFF4B);
        check("b_m24_w_i", 32'(bus_b.w_i), 32'hFFFF4B);
      end
      if (c == 95) begin
        check("b_m31_w_r", 32'(bus_b.w_r), 32'hFFFF01);
        check("b_m31_w_i", 32'(bus_b.w_i), 32'hFFFFE7);
      end
      if (c == 96) check("b_wrap_w_r", 32'(bus_b.w_r), 32'h000100);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
